// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//
// Target-side SRAM model on the request bus (addr/din/wen). It holds a
// 2**AW x DW word array. A write is committed on the edge that accepts it.
// A read is sampled into a fixed-latency pipeline, and its data comes back on
// dout/dout_vld RD_LAT cycles after the accept edge.
//
// After every BURST_LIMIT accepted requests the block raises busy for
// STALL_CYC cycles. This models a bank precharge and makes the initiator hold
// its request. Reads that are already in flight still complete during the
// stall.
//
// Optional feature: define SRAM_PARITY_EN to store one parity bit per word.
// The stored bit is ^din, inverted when inj_par is set on the write accept.
// par_err is raised alongside dout_vld when ^dout differs from the stored bit.
// dout is never corrected. Without the macro, par_err is tied to 0 and
// inj_par is ignored. The port list is the same in both builds.
//
// Ports
//   clk       in   1    clock, rising edge
//   rstn      in   1    asynchronous active-low reset
//   req       in   1    request strobe, qualifies addr/din/wen
//   addr      in   AW   word address
//   din       in   DW   write data
//   wen       in   1    1 = write, 0 = read
//   inj_par   in   1    invert stored parity on this write (parity build only)
//   busy      out  1    1 = request not accepted this cycle
//   dout      out  DW   read data, holds its value between pulses
//   dout_vld  out  1    one-cycle pulse, dout valid
//   par_err   out  1    parity mismatch, aligned with dout_vld
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int AW          = 15,
  parameter int DW          = 256,
  parameter int RD_LAT      = 2,
  parameter int BURST_LIMIT = 16,
  parameter int STALL_CYC   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          wen,
  input  logic          inj_par,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          par_err
);

  localparam int BCW = $clog2(BURST_LIMIT + 1);
  localparam int SCW = $clog2(STALL_CYC + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST_LIMIT - 1);
  localparam logic [SCW-1:0] STALL_INIT = SCW'(STALL_CYC - 1);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  state_t         state_reg;
  logic [BCW-1:0] burst_cnt_reg;
  logic [SCW-1:0] stall_cnt_reg;
  logic           busy_reg;

  logic accept;
  logic rd_accept;

  // busy is registered, so the accept decision depends only on req and
  // state that was already settled before this edge.
  assign accept    = req && !busy_reg;
  assign rd_accept = accept && !wen;
  assign busy      = busy_reg;

  // ---------------------------------------------------------------------------
  // Burst / stall control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_RUN;
      burst_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accept) begin
            if (burst_cnt_reg == BURST_LAST) begin
              // The accept that reaches the limit starts the stall.
              // busy goes high on the very next cycle.
              burst_cnt_reg <= '0;
              stall_cnt_reg <= STALL_INIT;
              busy_reg      <= 1'b1;
              state_reg     <= ST_STALL;
            end else begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
          end
        end
        ST_STALL: begin
          // stall_cnt is loaded with STALL_CYC-1, so busy stays high for
          // exactly STALL_CYC cycles.
          if (stall_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end else begin
            stall_cnt_reg <= stall_cnt_reg - 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // The array is deliberately not reset, so its contents survive rstn.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (accept && wen) begin
      mem[addr] <= din;
    end
  end

`ifdef SRAM_PARITY_EN
  logic mem_par [2**AW];

  always_ff @(posedge clk) begin
    if (accept && wen) begin
      mem_par[addr] <= (^din) ^ inj_par;
    end
  end
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
`endif

  // ---------------------------------------------------------------------------
  // Read pipeline
  // Stage 0 is the registered array read taken on the accept edge. The output
  // register that follows the last stage puts dout_vld exactly RD_LAT cycles
  // after the accept edge. Only the valid bits are reset; data bits are not,
  // so a reset drops every in-flight read.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : gen_stage
      logic [DW-1:0] data_reg;
      logic          vld_reg;
`ifdef SRAM_PARITY_EN
      logic          par_reg;
`endif

      if (gi == 0) begin : gen_head
        always_ff @(posedge clk) begin
          if (rd_accept) begin
            data_reg <= mem[addr];
`ifdef SRAM_PARITY_EN
            par_reg  <= mem_par[addr];
`endif
          end
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) vld_reg <= 1'b0;
          else       vld_reg <= rd_accept;
        end
      end else begin : gen_tail
        always_ff @(posedge clk) begin
          data_reg <= gen_stage[gi-1].data_reg;
`ifdef SRAM_PARITY_EN
          par_reg  <= gen_stage[gi-1].par_reg;
`endif
        end

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) vld_reg <= 1'b0;
          else       vld_reg <= gen_stage[gi-1].vld_reg;
        end
      end
    end
  endgenerate

  logic          last_vld;
  logic [DW-1:0] last_data;
  logic          last_perr;

  assign last_vld  = gen_stage[RD_LAT-1].vld_reg;
  assign last_data = gen_stage[RD_LAT-1].data_reg;
`ifdef SRAM_PARITY_EN
  assign last_perr = (^last_data) != gen_stage[RD_LAT-1].par_reg;
`else
  assign last_perr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register. dout only loads on a valid beat, so it holds its last
  // value while dout_vld is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      dout_vld <= last_vld;
      par_err  <= last_vld && last_perr;
      if (last_vld) begin
        dout <= last_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//
// Bench for sram_responder. It uses directed sequences followed by randomized
// ones, and checks them against a behavioural model.
//
// The model has three parts:
//   - an associative array holding the word contents and the injected-parity
//     flags;
//   - a queue of expected read returns, each stamped with the edge it is due;
//   - a count of accepts plus a count of remaining busy cycles, which
//     together give the accept/stall pattern.
//
// Every cycle the bench compares busy, dout_vld, dout and par_err on the
// falling edge. Inputs are driven on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  localparam int AW     = 15;
  localparam int DW     = 256;
  localparam int RD_LAT = 2;
  localparam int BL     = 16;
  localparam int SC     = 2;

  logic          clk;
  logic          rstn;
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          wen;
  logic          inj_par;
  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          par_err;

  sram_responder #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .BURST_LIMIT(BL), .STALL_CYC(SC)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .addr(addr), .din(din), .wen(wen),
    .inj_par(inj_par), .busy(busy), .dout(dout), .dout_vld(dout_vld),
    .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          perr;
  } rd_t;

  rd_t           rdq[$];
  logic [DW-1:0] ref_mem [int];
  logic          ref_inj [int];
  int            edge_n;
  int            n_acc;
  int            stall_left;
  logic [DW-1:0] exp_dout;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, expected %h", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one clock cycle. The model advances on the rising edge and the DUT
  // outputs are checked on the following falling edge.
  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic inj, output bit acc);
    rd_t  t;
    logic exp_vld;
    logic exp_perr;
    req = r; wen = w; addr = a; din = d; inj_par = inj;
    @(posedge clk);
    edge_n++;
    acc = 1'b0;
    if (stall_left > 0) begin
      stall_left--;
    end else if (r) begin
      acc = 1'b1;
      if (w) begin
        ref_mem[int'(a)] = d;
        ref_inj[int'(a)] = inj;
      end else begin
        t.due  = edge_n + RD_LAT;
        t.data = ref_mem[int'(a)];
`ifdef SRAM_PARITY_EN
        t.perr = ref_inj[int'(a)];
`else
        t.perr = 1'b0;
`endif
        rdq.push_back(t);
      end
      n_acc++;
      if (n_acc == BL) begin
        n_acc      = 0;
        stall_left = SC;
      end
    end
    @(negedge clk);
    exp_vld  = 1'b0;
    exp_perr = 1'b0;
    if (rdq.size() > 0 && rdq[0].due == edge_n) begin
      t        = rdq.pop_front();
      exp_vld  = 1'b1;
      exp_perr = t.perr;
      exp_dout = t.data;
    end
    check("busy", busy, stall_left > 0);
    check("dout_vld", dout_vld, exp_vld);
    check("dout", dout, exp_dout);
    check("par_err", par_err, exp_perr);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  // Hold the request until it is accepted. The wait is bounded.
  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic inj, output int tries);
    bit acc;
    tries = 0;
    do begin
      drive(1'b1, w, a, d, inj, acc);
      tries++;
    end while (!acc && tries < 20);
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    req = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_dout_vld", dout_vld, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_par_err", par_err, 1'b0);
    rstn = 1'b1;
    rdq.delete();
    n_acc      = 0;
    stall_left = 0;
    exp_dout   = '0;
  endtask

  logic [AW-1:0] pool [8];
  logic [DW-1:0] pat_a5;
  int            tries;

  initial begin
    n_cmp = 0; n_bad = 0; edge_n = 0; n_acc = 0; stall_left = 0;
    exp_dout = '0;
    req = 1'b0; wen = 1'b0; addr = '0; din = '0; inj_par = 1'b0;
    pat_a5 = {32{8'hA5}};
    @(negedge clk);
    do_reset();

    // Write then read the same address.
    issue(1'b1, 15'h0005, pat_a5, 1'b0, tries);
    issue(1'b0, 15'h0005, '0, 1'b0, tries);
    idle(4);

    // Reset while a read is in flight. The dropped read must never appear.
    issue(1'b0, 15'h0005, '0, 1'b0, tries);
    do_reset();
    idle(4);

    // Burst limit. The 16th accept is a read, and its data must return
    // during the stall. The 17th request is held and taken on cycle 19.
    for (int i = 0; i < BL - 1; i++) issue(1'b1, AW'(i + 32), rand_word(), 1'b0, tries);
    issue(1'b0, 15'h0005, '0, 1'b0, tries);
    issue(1'b0, 15'h0005, '0, 1'b0, tries);
    check("held_accept_tries", 32'(tries), 32'(SC + 1));
    idle(4);

    // Back-to-back reads across the address range.
    issue(1'b1, 15'h0000, rand_word(), 1'b0, tries);
    issue(1'b1, 15'h7FFF, rand_word(), 1'b0, tries);
    issue(1'b0, 15'h0000, '0, 1'b0, tries);
    issue(1'b0, 15'h7FFF, '0, 1'b0, tries);
    issue(1'b0, 15'h0000, '0, 1'b0, tries);
    idle(4);

    // Parity injection, then a clean write/read.
    issue(1'b1, 15'h0010, rand_word(), 1'b1, tries);
    issue(1'b0, 15'h0010, '0, 1'b0, tries);
    issue(1'b1, 15'h0011, rand_word(), 1'b0, tries);
    issue(1'b0, 15'h0011, '0, 1'b0, tries);
    idle(4);

    // Randomized traffic over a pool of initialised addresses.
    pool[0] = 15'h0005; pool[1] = 15'h0000; pool[2] = 15'h7FFF; pool[3] = 15'h0010;
    pool[4] = 15'h0011;
    for (int i = 5; i < 8; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 8; i++) issue(1'b1, pool[i], rand_word(), 1'($urandom), tries);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        issue(1'($urandom), pool[$urandom_range(0, 7)], rand_word(),
              1'($urandom), tries);
      end
    end
    idle(RD_LAT + 3);
    check("drained", 32'(rdq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
